// File: rtl/fcp6_pkg.sv
// Shared definitions for the FCP6 2-bit serial link: beat qualifiers, header
// field positions, payload geometry and the responder state encoding.
package fcp6_pkg;

   localparam logic [1:0] CTRL_IDLE   = 2'b00;
   localparam logic [1:0] CTRL_HEADER = 2'b01;
   localparam logic [1:0] CTRL_DATA   = 2'b10;
   localparam logic [1:0] CTRL_END    = 2'b11;

   localparam int RW_BIT   = 7;
   localparam int ID_MSB   = 6;
   localparam int ID_LSB   = 4;
   localparam int ADDR_MSB = 3;
   localparam int ADDR_LSB = 0;

   localparam int BEATS_PER_BYTE = 4;
   localparam int BEAT_CNT_W     = 3;
   localparam int REG_DEPTH      = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_IGNORE,
      ST_WDATA,
      ST_WEND,
      ST_TURN,
      ST_RDATA
   } fcp6_state_e;

   // Even-parity beat that trails a payload byte when parity is enabled.
   function automatic logic [1:0] parity_beat(input logic [7:0] value);
      return {1'b0, ^value};
   endfunction

endpackage

// File: rtl/fcp6_beat_shifter.sv
// 2-bit-in / 8-bit-out shift register with a beat counter. Assembles header and
// write bytes, and serialises a loaded read byte MSB pair first.
module fcp6_beat_shifter
   import fcp6_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  load_i,
   input  logic [7:0]            load_data_i,
   input  logic                  shift_i,
   input  logic                  clr_i,
   input  logic [1:0]            data_i,
   output logic [7:0]            byte_o,
   output logic [1:0]            msb_pair_o,
   output logic [BEAT_CNT_W-1:0] count_o
);

   logic [7:0]            byte_q,  byte_d;
   logic [BEAT_CNT_W-1:0] count_q, count_d;

   always_comb begin
      byte_d  = byte_q;
      count_d = count_q;
      if (load_i) begin
         byte_d  = load_data_i;
         count_d = '0;
      end else begin
         if (shift_i) begin
            byte_d  = {byte_q[5:0], data_i};
            count_d = count_q + BEAT_CNT_W'(1);
         end
         // Clear beats the increment so the last header beat can shift and restart the count.
         if (clr_i) begin
            count_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         byte_q  <= '0;
         count_q <= '0;
      end else begin
         byte_q  <= byte_d;
         count_q <= count_d;
      end
   end

   assign byte_o     = byte_q;
   assign msb_pair_o = byte_q[7:6];
   assign count_o    = count_q;

endmodule

// File: rtl/fcp6_responder.sv
// FCP6 responder: decodes master beats, commits writes to a 16x8 register file and
// serves reads. Define FCP6_PARITY_EN to add an even-parity beat to every payload.
module fcp6_responder
   import fcp6_pkg::*;
#(
   parameter logic [2:0] SLAVE_ID  = 3'd6,
   parameter logic [7:0] REG_RESET = 8'h00
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] ctrl_in,
   input  logic [1:0] data_in,
   output logic [1:0] data_out,
   output logic       data_valid_out,
   output logic       ack,
   output logic       err,
   output logic       busy,
   output logic [7:0] received_data,
   output logic [3:0] received_addr
);

   localparam logic [BEAT_CNT_W-1:0] LAST_BYTE_BEAT = BEAT_CNT_W'(BEATS_PER_BYTE - 1);
`ifdef FCP6_PARITY_EN
   localparam logic [BEAT_CNT_W-1:0] PARITY_BEAT  = BEAT_CNT_W'(BEATS_PER_BYTE);
   localparam logic [BEAT_CNT_W-1:0] LAST_RD_BEAT = PARITY_BEAT;
`else
   localparam logic [BEAT_CNT_W-1:0] LAST_RD_BEAT = LAST_BYTE_BEAT;
`endif

   fcp6_state_e state_q, state_d;
   logic        ack_q, ack_d;
   logic        err_q, err_d;
   logic        fault;
   logic [3:0]  addr_q, addr_d;
   logic [7:0]  received_data_q;
   logic [3:0]  received_addr_q;
   logic        wr_en;

   logic [7:0]           regfile_q [REG_DEPTH];
   logic [7:0]           rd_data_q;
   logic [REG_DEPTH-1:0] wr_sel;

   logic                  sh_load, sh_shift, sh_clr;
   logic [7:0]            sh_byte;
   logic [1:0]            sh_msb_pair;
   logic [BEAT_CNT_W-1:0] sh_count;

   logic [7:0] hdr_byte;
   logic [3:0] hdr_addr;

   // The header byte is complete combinationally while its 4th beat is on the wire.
   assign hdr_byte = {sh_byte[5:0], data_in};
   assign hdr_addr = hdr_byte[ADDR_MSB:ADDR_LSB];

   fcp6_beat_shifter u_shifter (
      .clk         (clk),
      .rst         (rst),
      .load_i      (sh_load),
      .load_data_i (rd_data_q),
      .shift_i     (sh_shift),
      .clr_i       (sh_clr),
      .data_i      (data_in),
      .byte_o      (sh_byte),
      .msb_pair_o  (sh_msb_pair),
      .count_o     (sh_count)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         ack_q           <= 1'b0;
         err_q           <= 1'b0;
         addr_q          <= '0;
         received_data_q <= REG_RESET;
         received_addr_q <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         addr_q  <= addr_d;
         if (wr_en) begin
            received_data_q <= sh_byte;
            received_addr_q <= addr_q;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      fault    = 1'b0;
      addr_d   = addr_q;
      wr_en    = 1'b0;
      sh_load  = 1'b0;
      sh_shift = 1'b0;
      sh_clr   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (ctrl_in == CTRL_HEADER) begin
               sh_shift = 1'b1;
               state_d  = ST_HDR;
            end
         end
         ST_HDR: begin
            if (ctrl_in != CTRL_HEADER) begin
               fault = 1'b1;
            end else begin
               sh_shift = 1'b1;
               if (sh_count == LAST_BYTE_BEAT) begin
                  sh_clr = 1'b1;
                  addr_d = hdr_addr;
                  if (hdr_byte[ID_MSB:ID_LSB] != SLAVE_ID) begin
                     state_d = ST_IGNORE;
                  end else if (hdr_byte[RW_BIT]) begin
                     state_d = ST_TURN;
                  end else begin
                     state_d = ST_WDATA;
                  end
               end
            end
         end
         ST_IGNORE: begin
            if (ctrl_in == CTRL_END || ctrl_in == CTRL_IDLE) begin
               sh_clr  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_WDATA: begin
            if (ctrl_in != CTRL_DATA) begin
               fault = 1'b1;
            end else begin
`ifdef FCP6_PARITY_EN
               if (sh_count == PARITY_BEAT) begin
                  if (data_in == parity_beat(sh_byte)) begin
                     state_d = ST_WEND;
                  end else begin
                     fault = 1'b1;
                  end
               end else begin
                  sh_shift = 1'b1;
               end
`else
               sh_shift = 1'b1;
               if (sh_count == LAST_BYTE_BEAT) begin
                  state_d = ST_WEND;
               end
`endif
            end
         end
         ST_WEND: begin
            if (ctrl_in == CTRL_END) begin
               wr_en   = 1'b1;
               ack_d   = 1'b1;
               sh_clr  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               fault = 1'b1;
            end
         end
         ST_TURN: begin
            if (ctrl_in != CTRL_IDLE) begin
               fault = 1'b1;
            end else begin
               sh_load = 1'b1;
               state_d = ST_RDATA;
            end
         end
         ST_RDATA: begin
            if (ctrl_in != CTRL_IDLE) begin
               fault = 1'b1;
            end else if (sh_count == LAST_RD_BEAT) begin
               ack_d   = 1'b1;
               sh_clr  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               sh_shift = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (fault) begin
         err_d    = 1'b1;
         sh_shift = 1'b0;
         sh_clr   = 1'b1;
         state_d  = ST_IDLE;
      end
   end

`ifdef FCP6_PARITY_EN
   logic [1:0] par_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         par_q <= '0;
      end else if (sh_load) begin
         par_q <= parity_beat(rd_data_q);
      end
   end
`endif

   always_comb begin
      busy           = (state_q != ST_IDLE) && (state_q != ST_IGNORE);
      data_valid_out = (state_q == ST_RDATA);
      data_out       = 2'b00;
      if (state_q == ST_RDATA) begin
         data_out = sh_msb_pair;
`ifdef FCP6_PARITY_EN
         if (sh_count == PARITY_BEAT) begin
            data_out = par_q;
         end
`endif
      end
   end

   generate
      for (genvar gi = 0; gi < REG_DEPTH; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_en && (addr_q == 4'(gi));
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_DEPTH; i++) begin
            regfile_q[i] <= REG_RESET;
         end
      end else begin
         for (int i = 0; i < REG_DEPTH; i++) begin
            if (wr_sel[i]) begin
               regfile_q[i] <= sh_byte;
            end
         end
      end
   end

   // Registered read addressed by the header as it completes, ready for the turnaround load.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= regfile_q[hdr_addr];
      end
   end

   assign ack           = ack_q;
   assign err           = err_q;
   assign received_data = received_data_q;
   assign received_addr = received_addr_q;

endmodule
